// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving a 16-bit ALU and an 8 x 16 register file.
// Ports: clk, rst_n, in_valid/in_instr/in_ready handshake, done, result, flags, dbg_addr/dbg_data.

// alu: combinational 16-bit ALU.
// Ports: op (3b), a, b (W), y (W) result, flags {Z,S,C,V}.
module alu #(
   parameter int W = 16
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic [3:0]   flags
);

   logic [W:0] sum;
   logic [W:0] diff;
   logic       c;
   logic       v;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y = '0;
      c = 1'b0;
      v = 1'b0;
      unique case (op)
         3'b000: begin
            y = sum[W-1:0];
            c = sum[W];
            v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
         end
         3'b001: begin
            y = diff[W-1:0];
            // bit W of the widened difference is the borrow
            c = diff[W];
            v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
         end
         3'b010: y = a & b;
         3'b011: y = a | b;
         3'b100: y = a ^ b;
         3'b101: y = ~a;
         default: y = '0;
      endcase
   end

   assign flags = {(y == '0), y[W-1], c, v};

endmodule

// alu_seq_ctrl: IDLE -> READ -> EXEC -> WB sequencer, one instruction per 4 cycles.
// Ports: see file banner; in_ready is (state == IDLE), done is high during WB.
module alu_seq_ctrl #(
   parameter int REGS = 8,
   parameter int W    = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [15:0]  in_instr,
   output logic         in_ready,
   output logic         done,
   output logic [W-1:0] result,
   output logic [3:0]   flags,
   input  logic [2:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   localparam logic [2:0] OP_LDL = 3'b110;
   localparam logic [2:0] OP_LDH = 3'b111;

   state_t       state_q;
   state_t       state_d;

   logic [15:0]  ir;
   logic [W-1:0] rf [REGS];
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] stage_val;
   logic [3:0]   stage_flags;
   logic [W-1:0] result_q;
   logic [3:0]   flags_q;

   logic [2:0]   ir_op;
   logic [2:0]   ir_rd;
   logic [2:0]   ir_rs1;
   logic [2:0]   ir_rs2;
   logic [7:0]   ir_imm;

   logic         is_ldl;
   logic         is_ldh;
   logic         is_alu;

   logic [W-1:0] alu_y;
   logic [3:0]   alu_f;
   logic [W-1:0] rd_cur;
   logic [W-1:0] exec_val;

   logic         accept;
   logic         ld_ops;
   logic         ld_stage;
   logic         wb_en;

   assign ir_op  = ir[15:13];
   assign ir_rd  = ir[12:10];
   assign ir_rs1 = ir[9:7];
   assign ir_rs2 = ir[6:4];
   assign ir_imm = ir[7:0];

   assign is_ldl = (ir_op == OP_LDL);
   assign is_ldh = (ir_op == OP_LDH);
   assign is_alu = !(is_ldl || is_ldh);

   alu #(.W(W)) u_alu (
      .op    (ir_op),
      .a     (op_a),
      .b     (op_b),
      .y     (alu_y),
      .flags (alu_f)
   );

   assign rd_cur = rf[ir_rd];

   // LDH keeps the low byte of rd as it stands in EXEC
   always_comb begin
      exec_val = alu_y;
      unique case (1'b1)
         is_ldl:  exec_val = {8'h00, ir_imm};
         is_ldh:  exec_val = {ir_imm, rd_cur[7:0]};
         default: exec_val = alu_y;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      ld_ops   = 1'b0;
      ld_stage = 1'b0;
      wb_en    = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            ld_ops  = 1'b1;
            state_d = EXEC;
         end
         EXEC: begin
            ld_stage = 1'b1;
            state_d  = WB;
         end
         WB: begin
            wb_en   = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir          <= '0;
         op_a        <= '0;
         op_b        <= '0;
         stage_val   <= '0;
         stage_flags <= '0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         if (accept) begin
            ir <= in_instr;
         end
         if (ld_ops) begin
            op_a <= rf[ir_rs1];
            op_b <= rf[ir_rs2];
         end
         if (ld_stage) begin
            stage_val   <= exec_val;
            stage_flags <= alu_f;
         end
         if (wb_en) begin
            result_q <= stage_val;
            if (is_alu) begin
               flags_q <= stage_flags;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REGS; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_en) begin
         rf[ir_rd] <= stage_val;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign result   = result_q;
   assign flags    = flags_q;
   assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl.
// Drives instructions, checks registers, result, flags and handshake timing.
module tb_alu_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        done;
   logic [15:0] result;
   logic [3:0]  flags;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int checks;
   int errors;

   alu_seq_ctrl #(.REGS(8), .W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_instr (in_instr),
      .in_ready (in_ready),
      .done     (done),
      .result   (result),
      .flags    (flags),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] f_alu(input logic [2:0] op,
                                         input logic [2:0] rd,
                                         input logic [2:0] rs1,
                                         input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 4'b0000};
   endfunction

   function automatic logic [15:0] f_ld(input logic [2:0] op,
                                        input logic [2:0] rd,
                                        input logic [7:0] imm);
      return {op, rd, 2'b00, imm};
   endfunction

   task automatic peek(input logic [2:0] a, output logic [15:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   // issue one instruction from IDLE and return just after it retires
   task automatic exec(input logic [15:0] instr);
      bit seen;
      seen     = 1'b0;
      in_instr = instr;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL exec_timeout instr=%h: done not seen", instr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL rst_done got=%b exp=0", done);
      end
      checks++;
      if (result !== 16'h0000 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL rst_res_flags got=%h/%b exp=0000/0000", result, flags);
      end
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), d);
         checks++;
         if (d !== 16'h0000) begin
            errors++;
            $display("FAIL rst_reg r%0d got=%h exp=0000", i, d);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_overflow();
      logic [15:0] d;
      exec(f_ld(3'b110, 3'd1, 8'hFF));
      exec(f_ld(3'b111, 3'd1, 8'h7F));
      peek(3'd1, d);
      checks++;
      if (d !== 16'h7FFF) begin
         errors++;
         $display("FAIL ldh_r1 got=%h exp=7fff", d);
      end
      exec(f_ld(3'b110, 3'd2, 8'h01));
      exec(f_alu(3'b000, 3'd3, 3'd1, 3'd2));
      peek(3'd3, d);
      checks++;
      if (d !== 16'h8000 || result !== 16'h8000) begin
         errors++;
         $display("FAIL add_ovf r3/result got=%h/%h exp=8000", d, result);
      end
      checks++;
      if (flags !== 4'b0101) begin
         errors++;
         $display("FAIL add_ovf_flags got=%b exp=0101", flags);
      end
   endtask

   task automatic test_not_sub();
      logic [15:0] d;
      exec(f_ld(3'b110, 3'd1, 8'h00));
      exec(f_alu(3'b101, 3'd2, 3'd1, 3'd7));
      peek(3'd2, d);
      checks++;
      if (d !== 16'hFFFF) begin
         errors++;
         $display("FAIL not_r2 got=%h exp=ffff", d);
      end
      exec(f_alu(3'b000, 3'd3, 3'd2, 3'd2));
      peek(3'd3, d);
      checks++;
      if (d !== 16'hFFFE || flags !== 4'b0110) begin
         errors++;
         $display("FAIL add_carry r3/flags got=%h/%b exp=fffe/0110", d, flags);
      end
      exec(f_alu(3'b001, 3'd4, 3'd1, 3'd1));
      peek(3'd4, d);
      checks++;
      if (d !== 16'h0000 || flags !== 4'b1000) begin
         errors++;
         $display("FAIL sub_zero r4/flags got=%h/%b exp=0000/1000", d, flags);
      end
      exec(f_ld(3'b110, 3'd7, 8'h12));
      checks++;
      if (flags !== 4'b1000) begin
         errors++;
         $display("FAIL ldl_keeps_flags got=%b exp=1000", flags);
      end
      exec(f_alu(3'b001, 3'd5, 3'd1, 3'd2));
      peek(3'd5, d);
      checks++;
      if (d !== 16'h0001 || flags !== 4'b0010) begin
         errors++;
         $display("FAIL sub_borrow r5/flags got=%h/%b exp=0001/0010", d, flags);
      end
   endtask

   task automatic test_logic();
      logic [15:0] d;
      logic [2:0]  ops [3];
      logic [15:0] exp [3];
      ops[0] = 3'b010; exp[0] = 16'h000C;
      ops[1] = 3'b011; exp[1] = 16'h003F;
      ops[2] = 3'b100; exp[2] = 16'h0033;
      exec(f_ld(3'b110, 3'd1, 8'h0F));
      exec(f_ld(3'b110, 3'd2, 8'h3C));
      for (int i = 0; i < 3; i++) begin
         exec(f_alu(ops[i], 3'd3, 3'd1, 3'd2));
         peek(3'd3, d);
         checks++;
         if (d !== exp[i] || flags !== 4'b0000) begin
            errors++;
            $display("FAIL logic op=%b r3/flags got=%h/%b exp=%h/0000",
                     ops[i], d, flags, exp[i]);
         end
      end
      exec(f_ld(3'b110, 3'd6, 8'h00));
      peek(3'd6, d);
      checks++;
      if (d !== 16'h0000 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL ldl_after_xor r6/flags got=%h/%b exp=0000/0000", d, flags);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] q [3];
      logic [15:0] d;
      logic        rdy;
      int          idx;
      int          ndone;
      q[0] = f_ld(3'b110, 3'd1, 8'h11);
      q[1] = f_ld(3'b110, 3'd2, 8'h22);
      q[2] = f_ld(3'b110, 3'd3, 8'h33);
      idx      = 0;
      ndone    = 0;
      in_instr = q[0];
      in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         rdy = in_ready;
         if (done) ndone++;
         checks++;
         if (rdy !== (c % 4 == 0) || done !== (c % 4 == 3)) begin
            errors++;
            $display("FAIL b2b_timing cyc=%0d ready/done got=%b/%b exp=%b/%b",
                     c, rdy, done, (c % 4 == 0), (c % 4 == 3));
         end
         @(posedge clk);
         if (rdy && in_valid) idx++;
         #1;
         if (idx < 3) in_instr = q[idx];
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (idx != 3 || ndone != 3) begin
         errors++;
         $display("FAIL b2b_count accepts/dones got=%0d/%0d exp=3/3", idx, ndone);
      end
      for (int i = 0; i < 3; i++) begin
         peek(3'(i + 1), d);
         checks++;
         if (d !== {8'h00, 4'(i + 1), 4'(i + 1)}) begin
            errors++;
            $display("FAIL b2b_reg r%0d got=%h exp=%h", i + 1, d,
                     {8'h00, 4'(i + 1), 4'(i + 1)});
         end
      end
   endtask

   task automatic test_self_add();
      exec(f_ld(3'b110, 3'd1, 8'h05));
      dbg_addr = 3'd1;
      in_instr = f_alu(3'b000, 3'd1, 3'd1, 3'd1);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || dbg_data !== 16'h0005) begin
         errors++;
         $display("FAIL self_add_wb done/dbg got=%b/%h exp=1/0005", done, dbg_data);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dbg_data !== 16'h000A || result !== 16'h000A) begin
         errors++;
         $display("FAIL self_add_after dbg/result got=%h/%h exp=000a", dbg_data, result);
      end
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL self_add_ret done/ready got=%b/%b exp=0/1", done, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      bit          seen;
      seen = 1'b0;
      exec(f_ld(3'b110, 3'd1, 8'h03));
      exec(f_ld(3'b110, 3'd2, 8'h04));
      in_instr = f_alu(3'b000, 3'd3, 3'd1, 3'd2);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst ready/done got=%b/%b exp=1/0", in_ready, done);
      end
      repeat (2) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_rst_done got=1 exp=0");
      end
      @(posedge clk);
      #1;
      checks++;
      if (result !== 16'h0000 || flags !== 4'b0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst_state res/flags/ready got=%h/%b/%b exp=0000/0000/1",
                  result, flags, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), d);
         checks++;
         if (d !== 16'h0000) begin
            errors++;
            $display("FAIL mid_rst_reg r%0d got=%h exp=0000", i, d);
         end
      end
      exec(f_ld(3'b110, 3'd2, 8'h09));
      peek(3'd2, d);
      checks++;
      if (d !== 16'h0009 || result !== 16'h0009) begin
         errors++;
         $display("FAIL post_rst r2/result got=%h/%h exp=0009", d, result);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = 16'h0000;
      dbg_addr = 3'd0;
      test_reset();
      test_add_overflow();
      test_not_sub();
      test_logic();
      test_back_to_back();
      test_self_add();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
